// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Brief    : Shared types and sizing helpers for the iterative radix-4 divider.
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef logic [1:0] r4_digit_t;

    // Wide enough to hold WIDTH/2 itself, not just WIDTH/2-1.
    function automatic int cnt_width(input int width);
        return $clog2(width / 2) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_r4_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_r4_step
//  Brief    : One radix-4 restoring step: shift in two dividend bits and
//             subtract the largest of 0/1/2/3 x divisor that fits.
//  Revision : 1.0  initial release
// ============================================================================
module div_r4_step
    import div_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH+1:0] rem_in,
    input  logic [1:0]       bits_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH+1:0] rem_out,
    output r4_digit_t        digit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_d1;
    logic [WIDTH+1:0] w_d2;
    logic [WIDTH+1:0] w_d3;

    // rem_in < dsr always holds, so its top two bits are zero and drop out here.
    assign w_shift = (rem_in << 2) | {{WIDTH{1'b0}}, bits_in};
    assign w_d1    = {2'b00, dsr};
    assign w_d2    = {1'b0, dsr, 1'b0};
    assign w_d3    = w_d1 + w_d2;

    always_comb begin
        digit   = 2'd0;
        rem_out = w_shift;
        if (w_shift >= w_d3) begin
            digit   = 2'd3;
            rem_out = w_shift - w_d3;
        end else if (w_shift >= w_d2) begin
            digit   = 2'd2;
            rem_out = w_shift - w_d2;
        end else if (w_shift >= w_d1) begin
            digit   = 2'd1;
            rem_out = w_shift - w_d1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iter_restoring_div.sv
`default_nettype none
// ============================================================================
//  Module   : iter_restoring_div
//  Brief    : Iterative radix-4 restoring divider, signed/unsigned, WIDTH/2
//             iterations plus one sign-fix cycle.
//  Revision : 1.0  initial release
// ============================================================================
module iter_restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("iter_restoring_div: WIDTH must be even and >= 4");
    end

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH+1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_quo;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_sgn;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH+1:0] w_rem_nxt;
    r4_digit_t        w_digit;

    assign w_sgn     = SIGNED_EN & is_signed;
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign w_dvd_mag = (w_sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dsr_mag = (w_sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_r4_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (r_rem),
        .bits_in (r_dvd[WIDTH-1:WIDTH-2]),
        .dsr     (r_dsr),
        .rem_out (w_rem_nxt),
        .digit   (w_digit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_quo       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dvd   <= w_dvd_mag;
                            r_dsr   <= w_dsr_mag;
                            r_neg_q <= w_sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_neg_r <= w_sgn && dividend[WIDTH-1];
                            r_rem   <= '0;
                            r_quo   <= '0;
                            r_cnt   <= CW'(WIDTH / 2);
                            busy    <= 1'b1;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_dvd <= r_dvd << 2;
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[WIDTH-3:0], w_digit};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= r_neg_q ? -r_quo : r_quo;
                    remainder   <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_restoring_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iter_restoring_div
//  Brief    : Self-checking bench: vector table, scoreboard queue, corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iter_restoring_div;

    localparam int W   = 64;
    localparam int LAT = W / 2 + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    iter_restoring_div #(
        .WIDTH     (W),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
        longint sa, sd;
        dz = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = a;
            sd = b;
            if (a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = '0;
            end else begin
                q = sa / sd;
                r = sa % sd;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got quotient %h remainder %h, expected no done",
                         quotient, remainder);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", W'(div_by_zero), W'(e.dz));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input logic [W-1:0] q, input logic [W-1:0] r, input bit dz);
        exp_t e;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        e.q = q; e.r = r; e.dz = dz;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // k = rising edges after the accepting edge before done is seen high.
    task automatic wait_done(output int k, output int bc);
        k  = 0;
        bc = 0;
        while (!done && k < 100) begin
            if (busy) bc++;
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_chk++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", k);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input logic [W-1:0] q, input logic [W-1:0] r, input bit dz);
        int k, bc;
        issue(a, b, s, q, r, dz);
        wait_done(k, bc);
        chk("done_latency", W'(k), W'(dz ? 0 : LAT));
        chk("busy_cycles", W'(bc), W'(dz ? 0 : LAT));
        @(negedge clk);
        chk("hold_quotient", quotient, q);
        chk("done_pulse", W'(done), W'(0));
    endtask

    initial begin
        int k, bc, seen;
        logic [W-1:0] a, b, q, r;
        bit s, dz;

        tbl[0]  = '{64'd87, 64'd5, 1'b0, 64'd17, 64'd2, 1'b0};
        tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hC000_0000_0000_0000, 1'b0,
                    64'd1, 64'h3FFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[2]  = '{-64'sd87, 64'd5, 1'b1, -64'sd17, -64'sd2, 1'b0};
        tbl[3]  = '{64'h8000_0000_0000_0000, -64'sd1, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b0};
        tbl[4]  = '{64'd59, 64'd0, 1'b0, '1, 64'd59, 1'b1};
        tbl[5]  = '{-64'sd59, 64'd0, 1'b1, '1, -64'sd59, 1'b1};
        tbl[6]  = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0};
        tbl[7]  = '{64'd7, -64'sd2, 1'b1, -64'sd3, 64'd1, 1'b0};
        tbl[8]  = '{-64'sd7, -64'sd2, 1'b1, 64'd3, -64'sd1, 1'b0};
        tbl[9]  = '{64'd5, 64'd9, 1'b0, 64'd0, 64'd5, 1'b0};
        tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        tbl[11] = '{-64'sd87, 64'd5, 1'b0, 64'd3689348814741910305, 64'd4, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_quotient", quotient, '0);
        chk("reset_remainder", remainder, '0);
        chk("reset_flags", W'({busy, done, div_by_zero}), W'(0));
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].dz);
        end

        // start during CALC must be ignored
        seen = n_done;
        issue(64'd87, 64'd5, 1'b0, 64'd17, 64'd2, 1'b0);
        repeat (9) @(negedge clk);
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bc);
        repeat (40) @(negedge clk);
        chk("busy_start_done_count", W'(n_done - seen), W'(1));
        run_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);

        // start in the DONE cycle must be ignored
        issue(64'd20, 64'd3, 1'b0, 64'd6, 64'd2, 1'b0);
        wait_done(k, bc);
        dividend = 64'd100;
        divisor  = 64'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_cycle_start_busy", W'(busy), W'(0));
        seen = n_done;
        repeat (5) @(negedge clk);
        chk("done_cycle_start_no_done", W'(n_done - seen), W'(0));
        run_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);

        // reset mid-operation aborts with no done
        @(negedge clk);
        dividend = 64'd87;
        divisor  = 64'd5;
        is_signed = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_quotient", quotient, '0);
        chk("abort_remainder", remainder, '0);
        chk("abort_flags", W'({busy, done, div_by_zero}), W'(0));
        seen = n_done;
        repeat (40) @(negedge clk);
        chk("abort_no_done", W'(n_done - seen), W'(0));
        run_op(64'd59, 64'd20, 1'b0, 64'd2, 64'd19, 1'b0);

        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            s = 1'($urandom_range(0, 1));
            model(a, b, s, q, r, dz);
            run_op(a, b, s, q, r, dz);
        end

        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iter_restoring_div.md
ITER_RESTORING_DIV -- requirements
Module: iter_restoring_div

Interface
REQ-001 Parameter WIDTH, 64, operand/result width; SHALL be even and >= 4.
REQ-002 Parameter SIGNED_EN, 1, when 0 the is_signed input SHALL be ignored and all operations SHALL be unsigned.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  request; SHALL be accepted only in IDLE.
REQ-006 is_signed  input  1  two's-complement mode for the accepted operation.
REQ-007 dividend  input  WIDTH  dividend, sampled on the accepting edge only.
REQ-008 divisor  input  WIDTH  divisor, sampled on the accepting edge only.
REQ-009 busy  output  1  high from the accepting edge until done is asserted.
REQ-010 done  output  1  single-cycle pulse; results valid in that cycle.
REQ-011 quotient  output  WIDTH  registered quotient.
REQ-012 remainder  output  WIDTH  registered remainder.
REQ-013 div_by_zero  output  1  registered flag, updated together with done.

Function
REQ-014 FSM states: IDLE, CALC, FIX, DONE.
- IDLE->CALC on start with divisor != 0.
- IDLE->DONE on start with divisor == 0.
- CALC->FIX after WIDTH/2 cycles.
- FIX->DONE.
- DONE->IDLE unconditionally.
REQ-015 CALC SHALL retire 2 quotient bits per cycle, MSB first, by radix-4 restoring selection against 1x, 2x and 3x |divisor|.
REQ-016 The partial remainder and the 2x/3x multiples SHALL be WIDTH+2 bits wide, so that no divisor value overflows the selection.
REQ-017 FIX SHALL apply the sign corrections; results SHALL be registered on the FIX->DONE edge.
REQ-018 Latency, start accepted at edge E0, divisor != 0: done SHALL be high in the cycle after edge E0+WIDTH/2+1 (33 cycles for WIDTH=64); busy SHALL be high for WIDTH/2+1 cycles.
REQ-019 Signed mode: operands SHALL be converted to magnitudes on acceptance.
- Quotient SHALL truncate toward zero.
- Remainder SHALL take the sign of the dividend.
REQ-020 Signed most-negative / -1: quotient SHALL be the most-negative value, remainder 0, no flag.
REQ-021 Divisor == 0, either mode: quotient SHALL be all ones, remainder SHALL be the dividend, div_by_zero SHALL be 1, and done SHALL follow at edge E0+1.
REQ-022 start while busy SHALL be ignored without side effects.
REQ-023 start may be asserted in the DONE cycle; it SHALL be ignored, and a new operation SHALL be accepted only from the following IDLE cycle.
REQ-024 quotient, remainder and div_by_zero SHALL hold their values until the next done.

Reset
REQ-025 reset low at a rising edge SHALL force IDLE.
REQ-026 reset low SHALL clear busy, done, div_by_zero, quotient and remainder to 0.
REQ-027 reset mid-operation SHALL abort the operation, and no done SHALL follow.
REQ-028 All internal counters and working registers SHALL be cleared on reset.

Structure
REQ-029 Shared package div_pkg SHALL hold:
- the FSM state enum;
- the 2-bit radix-digit type;
- the localparam function computing the iteration-counter width, $clog2(WIDTH/2)+1.
REQ-030 Radix-4 digit selection SHALL live in one combinational sub-module div_r4_step, parametrised by WIDTH.
- Inputs: partial remainder, next dividend bit pair, |divisor|.
- Outputs: new partial remainder, digit.

Verification
REQ-031 Unsigned 87 / 5 -> quotient 17, remainder 2, done at cycle 33, busy high for 33 cycles.
REQ-032 Unsigned 0xFFFF_FFFF_FFFF_FFFF / 0xC000_0000_0000_0000 -> quotient 1, remainder 0x3FFF_FFFF_FFFF_FFFF (3x-overflow check).
REQ-033 Signed -87 / 5 -> quotient -17, remainder -2; signed 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-034 59 / 0 -> quotient all ones, remainder 59, div_by_zero 1, done one cycle after acceptance.
REQ-035 start pulsed with 100 / 7 at cycle 10 of an 87 / 5 run -> only 17 r 2 is reported; a subsequent start in IDLE yields 14 r 2.
REQ-036 reset low at cycle 12 of an operation -> all outputs 0, no done; the next start of 59 / 20 -> quotient 2, remainder 19.
